rng_state_bank: RTL and testbench
=================================

RNG_STATE_BANK -- requirements
Module: rng_state_bank

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 32, bytes of state per channel (>=2).
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent state channels (>=2).
REQ-003 SHALL have parameter CH_W, default 2, channel-index width, equal to clog2(NUM_CH).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port w_ch  input  CH_W  channel selected for direct write.
REQ-007 SHALL have port w_en_bytes  input  NUM_BYTES  per-byte write enable; bit i enables byte i.
REQ-008 SHALL have port w_data_bytes  input  8*NUM_BYTES  write data; byte i on bits [8i+7:8i].
REQ-009 SHALL have port seed_start  input  1  one-cycle request to begin serial seed load.
REQ-010 SHALL have port seed_ch  input  CH_W  target channel, sampled with seed_start.
REQ-011 SHALL have port seed_valid  input  1  seed byte valid.
REQ-012 SHALL have port seed_data  input  8  seed byte.
REQ-013 SHALL have port seed_ready  output  1  loader accepts seed byte this cycle.
REQ-014 SHALL have port seed_busy  output  1  loader in LOAD state.
REQ-015 SHALL have port seed_done  output  1  one-cycle pulse after final seed byte stored.
REQ-016 SHALL have port rd_ch  input  CH_W  channel selected for readout.
REQ-017 SHALL have port q_bytes  output  8*NUM_BYTES  registered state of rd_ch.

Function
REQ-018 Direct write SHALL update byte i of channel w_ch at the clock edge where w_en_bytes[i]=1; bytes with enable 0 hold.
REQ-019 q_bytes SHALL be registered: value at edge N+1 equals channel rd_ch state as held after edge N (write at edge N visible at edge N+1).
REQ-020 Channel index >= NUM_CH SHALL make direct writes no-ops and read return all zeros; seed_start with such seed_ch SHALL be ignored.
REQ-021 Loader FSM SHALL have states IDLE, LOAD, DONE.
REQ-022 IDLE->LOAD on seed_start with valid seed_ch; byte counter cleared to 0, target channel latched.
REQ-023 In LOAD, seed_ready=1; each cycle with seed_valid&seed_ready SHALL write seed_data to byte[counter] of target channel and increment counter.
REQ-024 Acceptance of byte NUM_BYTES-1 SHALL move LOAD->DONE; DONE asserts seed_done for exactly one cycle, then returns to IDLE.
REQ-025 seed_ready SHALL be 0 in IDLE and DONE; seed_valid outside LOAD ignored.
REQ-026 seed_start while in LOAD or DONE SHALL be ignored.
REQ-027 While seed_busy, direct writes to the target channel SHALL be ignored entirely; direct writes to other channels proceed same cycle.
REQ-028 Bytes not yet loaded SHALL keep prior values until overwritten by the loader.

Reset
REQ-029 rst_n=0 SHALL immediately clear all channel state, q_bytes, counter to zero, FSM to IDLE, seed_ready/seed_busy/seed_done/parity_err to 0.
REQ-030 Reset during LOAD SHALL abort the load with no seed_done pulse.

Configuration
REQ-031 With RNG_STATE_PARITY_EN defined, SHALL store one even-parity bit per byte per channel and add output parity_err (1 bit), registered, set when any byte of rd_ch fails parity, aligned with q_bytes.
REQ-032 Without RNG_STATE_PARITY_EN, SHALL have no parity storage and no parity_err port; behaviour otherwise identical.

Verification
REQ-033 Reset 3 cycles then release -> q_bytes all zero for every rd_ch 0..3.
REQ-034 w_ch=1, write byte0=0xAA, byte2=0xFF; rd_ch=1 -> byte0 0xAA, byte1 0x00, byte2 0xFF one cycle after write; rd_ch=0 -> all zero.
REQ-035 seed_start seed_ch=2, stream 32 bytes 0x00..0x1F with seed_valid toggled every other cycle -> seed_done single pulse after byte 0x1F; channel 2 byte i = i.
REQ-036 During load of channel 2, direct write byte0=0x55 to ch2 and ch3 same cycle -> ch2 byte0 keeps seed value, ch3 byte0=0x55.
REQ-037 rst_n low after 10 seed bytes -> no seed_done, seed_busy 0, all state zero; new seed_start accepted after release.
REQ-038 (RNG_STATE_PARITY_EN) force stored parity bit flip via bench -> parity_err=1 when that channel is read, 0 for other channels.

Source files
------------

// File: rtl/rng_state_bank.sv
// ---------------------------------------------------------------------------
// rng_state_bank
//
// Bank of NUM_CH independent RNG state channels, each NUM_BYTES bytes wide.
// State can be updated two ways:
//   * direct write: any subset of bytes of channel w_ch in one cycle;
//   * serial seed load: a small loader FSM streams NUM_BYTES seed bytes,
//     in order, into one target channel using a valid/ready handshake.
// While a seed load is active, the loader owns its target channel and
// direct writes to that channel are dropped. Direct writes to other
// channels proceed in the same cycle.
// The state of channel rd_ch is presented on q_bytes one cycle later.
//
// Optional feature (macro RNG_STATE_PARITY_EN): one even-parity bit is
// stored per byte per channel. parity_err is registered alongside q_bytes
// and flags a parity failure in any byte of the channel being read.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   w_ch          direct-write channel
//   w_en_bytes    per-byte direct-write enable
//   w_data_bytes  direct-write data, byte i on [8i+7:8i]
//   seed_start    one-cycle request to start a seed load
//   seed_ch       seed target channel, sampled with seed_start
//   seed_valid    seed byte valid
//   seed_data     seed byte
//   seed_ready    loader accepts a seed byte this cycle
//   seed_busy     loader is loading
//   seed_done     one-cycle pulse after the final seed byte is stored
//   rd_ch         readout channel
//   q_bytes       registered state of rd_ch
//   parity_err    (RNG_STATE_PARITY_EN only) registered parity failure flag
// ---------------------------------------------------------------------------
module rng_state_bank #(
    parameter int NUM_BYTES = 32,
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CH_W-1:0]        w_ch,
    input  logic [NUM_BYTES-1:0]   w_en_bytes,
    input  logic [8*NUM_BYTES-1:0] w_data_bytes,
    input  logic                   seed_start,
    input  logic [CH_W-1:0]        seed_ch,
    input  logic                   seed_valid,
    input  logic [7:0]             seed_data,
    output logic                   seed_ready,
    output logic                   seed_busy,
    output logic                   seed_done,
    input  logic [CH_W-1:0]        rd_ch,
    output logic [8*NUM_BYTES-1:0] q_bytes
`ifdef RNG_STATE_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int CNT_W = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } ld_state_t;

    ld_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CH_W-1:0]  tgt_q;

    logic [NUM_BYTES-1:0][7:0] mem_q [NUM_CH];
`ifdef RNG_STATE_PARITY_EN
    logic [NUM_BYTES-1:0]      par_q [NUM_CH];
`endif

    logic seed_ch_ok;
    logic seed_accept;
    logic dir_blocked;

    // Out-of-range channel indices are only possible when NUM_CH is not a
    // power of two; the comparison folds away otherwise.
    assign seed_ch_ok  = int'(seed_ch) < NUM_CH;
    assign seed_accept = (state_q == S_LOAD) && seed_valid;
    assign dir_blocked = seed_busy && (w_ch == tgt_q);

    // -----------------------------------------------------------------------
    // Loader FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        seed_ready = 1'b0;
        seed_busy  = 1'b0;
        seed_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (seed_start && seed_ch_ok) state_d = S_LOAD;
            end
            S_LOAD: begin
                seed_ready = 1'b1;
                seed_busy  = 1'b1;
                if (seed_valid && (cnt_q == LAST_IDX)) state_d = S_DONE;
            end
            S_DONE: begin
                seed_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte counter and latched target channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tgt_q <= '0;
        end else if ((state_q == S_IDLE) && (state_d == S_LOAD)) begin
            cnt_q <= '0;
            tgt_q <= seed_ch;
        end else if (seed_accept) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the state array must read as zero straight out of reset,
            // so it is built from resettable flops rather than a RAM macro.
            for (int c = 0; c < NUM_CH; c++) begin
                mem_q[c] <= '0;
`ifdef RNG_STATE_PARITY_EN
                par_q[c] <= '0;
`endif
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (seed_accept && (tgt_q == CH_W'(c)) && (cnt_q == CNT_W'(i))) begin
                        mem_q[c][i] <= seed_data;
`ifdef RNG_STATE_PARITY_EN
                        par_q[c][i] <= ^seed_data;
`endif
                    end else if ((w_ch == CH_W'(c)) && w_en_bytes[i] && !dir_blocked) begin
                        mem_q[c][i] <= w_data_bytes[8*i +: 8];
`ifdef RNG_STATE_PARITY_EN
                        par_q[c][i] <= ^w_data_bytes[8*i +: 8];
`endif
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Readout: an index with no matching channel leaves the defaults (zero).
    // -----------------------------------------------------------------------
    logic [NUM_BYTES-1:0][7:0] rd_sel;
`ifdef RNG_STATE_PARITY_EN
    logic                      rd_perr;
`endif

    always_comb begin
        rd_sel = '0;
`ifdef RNG_STATE_PARITY_EN
        rd_perr = 1'b0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c)) begin
                rd_sel = mem_q[c];
`ifdef RNG_STATE_PARITY_EN
                for (int i = 0; i < NUM_BYTES; i++) begin
                    // Stored bit is even parity of the byte, so the XOR of
                    // byte and bit is 0 for an intact byte.
                    if (^{mem_q[c][i], par_q[c][i]}) rd_perr = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_bytes <= '0;
`ifdef RNG_STATE_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            q_bytes <= rd_sel;
`ifdef RNG_STATE_PARITY_EN
            parity_err <= rd_perr;
`endif
        end
    end

endmodule

// File: tb/tb_rng_state_bank.sv
// ---------------------------------------------------------------------------
// tb_rng_state_bank
//
// Directed bench for rng_state_bank with a bank-level reference model: the
// model holds the channel bytes as a plain array plus the loader progress
// (phase, next byte index, target) and is advanced once per clock from the
// same inputs the DUT sees. All outputs are compared against the model
// after every clock; hand-computed literal checks pin the model.
// Define RNG_STATE_PARITY_EN to also exercise the parity output.
// ---------------------------------------------------------------------------
module tb_rng_state_bank;

    localparam int NB  = 32;
    localparam int NCH = 4;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CW-1:0]     w_ch;
    logic [NB-1:0]     w_en_bytes;
    logic [8*NB-1:0]   w_data_bytes;
    logic              seed_start;
    logic [CW-1:0]     seed_ch;
    logic              seed_valid;
    logic [7:0]        seed_data;
    logic              seed_ready;
    logic              seed_busy;
    logic              seed_done;
    logic [CW-1:0]     rd_ch;
    logic [8*NB-1:0]   q_bytes;
`ifdef RNG_STATE_PARITY_EN
    logic              parity_err;
`endif

    rng_state_bank #(.NUM_BYTES(NB), .NUM_CH(NCH), .CH_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_ch         (w_ch),
        .w_en_bytes   (w_en_bytes),
        .w_data_bytes (w_data_bytes),
        .seed_start   (seed_start),
        .seed_ch      (seed_ch),
        .seed_valid   (seed_valid),
        .seed_data    (seed_data),
        .seed_ready   (seed_ready),
        .seed_busy    (seed_busy),
        .seed_done    (seed_done),
        .rd_ch        (rd_ch),
        .q_bytes      (q_bytes)
`ifdef RNG_STATE_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]      m [NCH][NB];
    int              phase;      // 0 idle, 1 loading, 2 done pulse
    int              ld_cnt;
    int              ld_tgt;
    logic [8*NB-1:0] exp_q;
    logic            exp_perr;
    logic            perr_forced;

    int n_vec;
    int n_err;
    int done_seen;

    task automatic check(input string name, input logic [8*NB-1:0] act,
                         input logic [8*NB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < NB; i++) m[c][i] = 8'h00;
        phase  = 0;
        ld_cnt = 0;
        ld_tgt = 0;
        exp_q  = '0;
        exp_perr = 1'b0;
    endtask

    task automatic compare_all();
        check("q_bytes",    q_bytes,    exp_q);
        check("seed_busy",  seed_busy,  phase == 1);
        check("seed_ready", seed_ready, phase == 1);
        check("seed_done",  seed_done,  phase == 2);
`ifdef RNG_STATE_PARITY_EN
        check("parity_err", parity_err, exp_perr);
`endif
    endtask

    // One clock: model advances on the same edge as the DUT, then every
    // output is compared on the following falling edge.
    task automatic step();
        logic [8*NB-1:0] nq;
        logic            np;
        int              ph;
        nq = '0;
        if (int'(rd_ch) < NCH)
            for (int i = 0; i < NB; i++) nq[8*i +: 8] = m[rd_ch][i];
        np = perr_forced && (rd_ch == 2'd3);
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            ph = phase;
            if (int'(w_ch) < NCH && !(ph == 1 && int'(w_ch) == ld_tgt))
                for (int i = 0; i < NB; i++)
                    if (w_en_bytes[i]) m[w_ch][i] = w_data_bytes[8*i +: 8];
            if (ph == 1 && seed_valid) begin
                m[ld_tgt][ld_cnt] = seed_data;
                ld_cnt++;
                if (ld_cnt == NB) phase = 2;
            end else if (ph == 2) begin
                phase = 0;
            end else if (ph == 0 && seed_start && int'(seed_ch) < NCH) begin
                phase  = 1;
                ld_cnt = 0;
                ld_tgt = int'(seed_ch);
            end
            exp_q    = nq;
            exp_perr = np;
        end
        @(negedge clk);
        if (seed_done) done_seen++;
        compare_all();
    endtask

    task automatic idle_inputs();
        w_ch         = '0;
        w_en_bytes   = '0;
        w_data_bytes = '0;
        seed_start   = 1'b0;
        seed_ch      = '0;
        seed_valid   = 1'b0;
        seed_data    = 8'h00;
    endtask

    // Reset is asserted mid-cycle; the clear must be visible immediately.
    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        check("rst_q_async",    q_bytes,   '0);
        check("rst_busy_async", seed_busy, 1'b0);
        check("rst_done_async", seed_done, 1'b0);
        model_clear();
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [8*NB-1:0] ramp;
        int              done_before;
        n_vec = 0;
        n_err = 0;
        done_seen   = 0;
        perr_forced = 1'b0;
        rst_n = 1'b0;
        rd_ch = '0;
        idle_inputs();
        model_clear();
        @(negedge clk);

        // --- reset, then every channel reads zero ---
        do_reset(3);
        for (int c = 0; c < NCH; c++) begin
            rd_ch = CW'(c);
            step();
            step();
            check("reset_zero_lit", q_bytes, '0);
        end

        // --- direct write to channel 1 ---
        w_ch = 2'd1;
        w_en_bytes = 32'h0000_0005;
        w_data_bytes = '0;
        w_data_bytes[7:0]   = 8'hAA;
        w_data_bytes[15:8]  = 8'h11;   // not enabled, must not land
        w_data_bytes[23:16] = 8'hFF;
        rd_ch = 2'd1;
        step();
        idle_inputs();
        step();
        check("wr_byte0_lit", q_bytes[7:0],   8'hAA);
        check("wr_byte1_lit", q_bytes[15:8],  8'h00);
        check("wr_byte2_lit", q_bytes[23:16], 8'hFF);
        rd_ch = 2'd0;
        step();
        check("wr_ch0_zero_lit", q_bytes, '0);

        // --- seed load of channel 2 ---
        seed_valid = 1'b1;             // ignored in idle
        seed_data  = 8'h77;
        step();
        idle_inputs();
        seed_start = 1'b1;
        seed_ch    = 2'd2;
        step();
        idle_inputs();
        check("load_busy_lit", seed_busy, 1'b1);
        rd_ch = 2'd2;
        for (int b = 0; b < NB; b++) begin
            seed_valid = 1'b0;
            if (b == 3) begin          // direct write to the loading channel
                w_ch = 2'd2; w_en_bytes = 32'h1; w_data_bytes[7:0] = 8'h55;
            end
            if (b == 4) begin          // direct write to another channel
                w_ch = 2'd3; w_en_bytes = 32'h1; w_data_bytes[7:0] = 8'h55;
            end
            if (b == 5) begin          // restart request mid-load
                seed_start = 1'b1; seed_ch = 2'd0;
            end
            step();
            idle_inputs();
            seed_valid = 1'b1;
            seed_data  = 8'(b);
            if (b == 6) begin          // blocked write in an accepting cycle
                w_ch = 2'd2; w_en_bytes = 32'h3; w_data_bytes[15:0] = 16'h5555;
            end
            step();
            idle_inputs();
        end
        check("done_after_last_lit", seed_done, 1'b1);
        step();
        check("done_single_lit", 32'(done_seen), 32'd1);
        step();
        ramp = '0;
        for (int i = 0; i < NB; i++) ramp[8*i +: 8] = 8'(i);
        check("seed_ramp_lit", q_bytes, ramp);
        rd_ch = 2'd3;
        step();
        step();
        check("ch3_byte0_lit", q_bytes[7:0], 8'h55);

        // --- reset in the middle of a load ---
        seed_start = 1'b1;
        seed_ch    = 2'd1;
        step();
        idle_inputs();
        for (int b = 0; b < 10; b++) begin
            seed_valid = 1'b1;
            seed_data  = 8'hC0 + 8'(b);
            step();
        end
        idle_inputs();
        done_before = done_seen;
        do_reset(2);
        check("abort_busy_lit", seed_busy, 1'b0);
        step();
        check("abort_no_done_lit", 32'(done_seen), 32'(done_before));
        rd_ch = 2'd1;
        step();
        step();
        check("abort_zero_lit", q_bytes, '0);
        seed_start = 1'b1;
        seed_ch    = 2'd0;
        step();
        idle_inputs();
        check("restart_busy_lit", seed_busy, 1'b1);
        for (int b = 0; b < 3; b++) begin
            seed_valid = 1'b1;
            seed_data  = 8'h9 + 8'(b);
            step();
        end
        idle_inputs();
        rd_ch = 2'd0;
        step();
        step();
        check("restart_bytes_lit", q_bytes[23:0], 24'h0B0A09);

`ifdef RNG_STATE_PARITY_EN
        // --- corrupted parity bit on channel 3 byte 0 ---
        force dut.par_q[3][0] = ~dut.par_q[3][0];
        perr_forced = 1'b1;
        rd_ch = 2'd3;
        step();
        step();
        check("perr_ch3_lit", parity_err, 1'b1);
        rd_ch = 2'd0;
        step();
        step();
        check("perr_ch0_lit", parity_err, 1'b0);
        release dut.par_q[3][0];
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
